// File: rtl/rpc_phy_sequencer.sv
// rpc_phy_sequencer: runs one RPC DRAM transaction at a time onto the pad layer.
// Pad outputs are either flops or pure decodes of the state flop.
module rpc_phy_sequencer #(
    parameter int unsigned CmdTurn = 2,
    parameter int unsigned RdLat   = 4,
    parameter int unsigned LenW    = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [31:0]     req_cmd_i,
    input  logic            req_write_i,
    input  logic [LenW-1:0] req_len_i,
    input  logic            wdata_valid_i,
    output logic            wdata_ready_o,
    input  logic [15:0]     wdata_i,
    output logic            rdata_valid_o,
    output logic [15:0]     rdata_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            out_csn_o,
    output logic            out_stb_o,
    output logic            clk_en_o,
    output logic            oe_db_o,
    output logic            oe_dqs_o,
    output logic            ie_db_o,
    output logic            ie_dqs_o,
    output logic            pd_en_db_o,
    output logic            pd_en_dqs_o,
    output logic [15:0]     out_db_o,
    output logic            out_dqs_o,
    output logic            out_dqsn_o,
    input  logic [15:0]     in_db_i
);

    typedef enum logic [3:0] {
        StIdle, StCmd0, StCmd1, StTurn, StWdata, StWpost, StRwait, StRdata, StDone
    } state_e;

    localparam logic [5:0] TurnLast  = 6'(CmdTurn - 1);
    localparam logic [5:0] RdLatLast = 6'(RdLat - 1);

    state_e          state_q;
    logic [15:0]     cmd_hi_q;
    logic            write_q;
    logic [LenW-1:0] len_q;
    logic [5:0]      wait_q;
    // One bit wider than len so a full 2^LenW burst never wraps early.
    logic [LenW:0]   beat_q;
    logic [15:0]     db_q;
    logic            dqs_q;
    logic [15:0]     rdata_q;
    logic            rdata_valid_q;
    logic            clk_en_q;
    logic [LenW:0]   len_ext;

    assign len_ext = {1'b0, len_q};

    // Sequencer state, counters and all registered pad/data outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cmd_hi_q      <= '0;
            write_q       <= 1'b0;
            len_q         <= '0;
            wait_q        <= '0;
            beat_q        <= '0;
            db_q          <= '0;
            dqs_q         <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            clk_en_q      <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        cmd_hi_q <= req_cmd_i[31:16];
                        write_q  <= req_write_i;
                        len_q    <= req_len_i;
                        db_q     <= req_cmd_i[15:0];
                        clk_en_q <= 1'b1;
                        state_q  <= StCmd0;
                    end
                end
                StCmd0: begin
                    db_q    <= cmd_hi_q;
                    state_q <= StCmd1;
                end
                StCmd1: begin
                    wait_q  <= '0;
                    state_q <= StTurn;
                end
                StTurn: begin
                    if (wait_q == TurnLast) begin
                        wait_q <= '0;
                        beat_q <= '0;
                        if (write_q) begin
                            dqs_q   <= 1'b0;
                            state_q <= StWdata;
                        end else begin
                            state_q <= StRwait;
                        end
                    end else begin
                        wait_q <= wait_q + 6'd1;
                    end
                end
                StWdata: begin
                    // The DRAM clock only runs in cycles where fresh data sits on the pads.
                    if (wdata_valid_i) begin
                        db_q     <= wdata_i;
                        dqs_q    <= ~dqs_q;
                        beat_q   <= beat_q + 1'b1;
                        clk_en_q <= 1'b1;
                        if (beat_q == len_ext) begin
                            state_q <= StWpost;
                        end
                    end else begin
                        clk_en_q <= 1'b0;
                    end
                end
                StWpost: begin
                    clk_en_q <= 1'b0;
                    state_q  <= StDone;
                end
                StRwait: begin
                    if (wait_q == RdLatLast) begin
                        state_q <= StRdata;
                    end else begin
                        wait_q <= wait_q + 6'd1;
                    end
                end
                StRdata: begin
                    rdata_q       <= in_db_i;
                    rdata_valid_q <= 1'b1;
                    beat_q        <= beat_q + 1'b1;
                    if (beat_q == len_ext) begin
                        clk_en_q <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Pad enables and handshakes decoded from the state flop only.
    always_comb begin
        req_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        done_o        = 1'b0;
        out_csn_o     = 1'b0;
        out_stb_o     = 1'b1;
        oe_db_o       = 1'b0;
        oe_dqs_o      = 1'b0;
        ie_db_o       = 1'b0;
        ie_dqs_o      = 1'b0;
        pd_en_db_o    = 1'b0;
        pd_en_dqs_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                out_csn_o   = 1'b1;
                pd_en_db_o  = 1'b1;
                pd_en_dqs_o = 1'b1;
            end
            StCmd0, StCmd1: begin
                out_stb_o = 1'b0;
                oe_db_o   = 1'b1;
            end
            StWdata: begin
                wdata_ready_o = 1'b1;
                oe_db_o       = 1'b1;
                oe_dqs_o      = 1'b1;
            end
            StWpost: begin
                oe_db_o  = 1'b1;
                oe_dqs_o = 1'b1;
            end
            StRwait, StRdata: begin
                ie_db_o  = 1'b1;
                ie_dqs_o = 1'b1;
            end
            StDone: begin
                out_csn_o = 1'b1;
                done_o    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy_o        = (state_q != StIdle);
    assign clk_en_o      = clk_en_q;
    assign out_db_o      = db_q;
    assign out_dqs_o     = dqs_q;
    assign out_dqsn_o    = ~dqs_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;

endmodule

// File: tb/tb_rpc_phy_sequencer.sv
// Directed bench for rpc_phy_sequencer: cycle tables plus multi-cycle corner cases.
module tb_rpc_phy_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_cmd_i;
    logic        req_write_i;
    logic [7:0]  req_len_i;
    logic        wdata_valid_i;
    logic        wdata_ready_o;
    logic [15:0] wdata_i;
    logic        rdata_valid_o;
    logic [15:0] rdata_o;
    logic        done_o;
    logic        busy_o;
    logic        out_csn_o;
    logic        out_stb_o;
    logic        clk_en_o;
    logic        oe_db_o;
    logic        oe_dqs_o;
    logic        ie_db_o;
    logic        ie_dqs_o;
    logic        pd_en_db_o;
    logic        pd_en_dqs_o;
    logic [15:0] out_db_o;
    logic        out_dqs_o;
    logic        out_dqsn_o;
    logic [15:0] in_db_i;

    always #5 clk_i = ~clk_i;

    rpc_phy_sequencer #(
        .CmdTurn(2),
        .RdLat  (4),
        .LenW   (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_cmd_i    (req_cmd_i),
        .req_write_i  (req_write_i),
        .req_len_i    (req_len_i),
        .wdata_valid_i(wdata_valid_i),
        .wdata_ready_o(wdata_ready_o),
        .wdata_i      (wdata_i),
        .rdata_valid_o(rdata_valid_o),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .out_csn_o    (out_csn_o),
        .out_stb_o    (out_stb_o),
        .clk_en_o     (clk_en_o),
        .oe_db_o      (oe_db_o),
        .oe_dqs_o     (oe_dqs_o),
        .ie_db_o      (ie_db_o),
        .ie_dqs_o     (ie_dqs_o),
        .pd_en_db_o   (pd_en_db_o),
        .pd_en_dqs_o  (pd_en_dqs_o),
        .out_db_o     (out_db_o),
        .out_dqs_o    (out_dqs_o),
        .out_dqsn_o   (out_dqsn_o),
        .in_db_i      (in_db_i)
    );

    typedef struct packed {
        logic        rv, wr;
        logic [7:0]  len;
        logic [31:0] cmd;
        logic        wv;
        logic [15:0] wd, indb;
    } vin_t;

    typedef struct packed {
        logic        rdy, busy, csn, stb, clk, oedb, oedqs, wrdy, iedb, iedqs, pddb, pddqs;
        logic [15:0] db;
        logic        dqs, dqsn, rv;
        logic [15:0] rd;
        logic        done;
    } vexp_t;

    typedef struct packed {
        vin_t  i;
        vexp_t e;
    } vec_t;

    vexp_t act;
    assign act = '{rdy: req_ready_o, busy: busy_o, csn: out_csn_o, stb: out_stb_o,
                   clk: clk_en_o, oedb: oe_db_o, oedqs: oe_dqs_o, wrdy: wdata_ready_o,
                   iedb: ie_db_o, iedqs: ie_dqs_o, pddb: pd_en_db_o, pddqs: pd_en_dqs_o,
                   db: out_db_o, dqs: out_dqs_o, dqsn: out_dqsn_o, rv: rdata_valid_o,
                   rd: rdata_o, done: done_o};

    int total = 0;
    int bad   = 0;

    // f = {rdy, csn, stb, clk_en, oe_db, oe_dqs, wdata_ready, ie}; s = {dqs, rvalid, done}.
    // Pull-downs are on only in IDLE, i.e. exactly when ready is high.
    function automatic vexp_t ex(input logic [7:0] f, input logic [15:0] db,
                                 input logic [2:0] s, input logic [15:0] rd);
        ex = '{rdy: f[7], busy: ~f[7], csn: f[6], stb: f[5], clk: f[4], oedb: f[3],
               oedqs: f[2], wrdy: f[1], iedb: f[0], iedqs: f[0], pddb: f[7], pddqs: f[7],
               db: db, dqs: s[2], dqsn: ~s[2], rv: s[1], rd: rd, done: s[0]};
    endfunction

    function automatic vin_t wrin(input logic rv);
        wrin = '{rv: rv, wr: 1'b1, len: 8'd0, cmd: 32'hA5A5_1234, wv: 1'b1, wd: 16'hBEEF,
                 indb: 16'h0000};
    endfunction

    function automatic vin_t rdin(input logic rv, input logic [15:0] indb);
        rdin = '{rv: rv, wr: 1'b0, len: 8'd1, cmd: 32'h1357_2468, wv: 1'b0, wd: 16'h0000,
                 indb: indb};
    endfunction

    task automatic apply(input vin_t v);
        req_valid_i   = v.rv;
        req_write_i   = v.wr;
        req_len_i     = v.len;
        req_cmd_i     = v.cmd;
        wdata_valid_i = v.wv;
        wdata_i       = v.wd;
        in_db_i       = v.indb;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    vec_t  tbl[$];
    vexp_t rst_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tgl, clk_lo, done_c, acc, nd, fl, e, s, pulses, rbad, first_p, last_p;
        int acc_c[2];
        int done_b[2];
        logic prev;
        logic csn_h[40];

        rst_exp = ex(8'b1110_0000, 16'h0000, 3'b000, 16'h0000);

        // Single-word write followed directly by a two-word read.
        tbl.push_back('{wrin(1'b1), ex(8'b1110_0000, 16'h0000, 3'b000, 16'h0000)});
        tbl.push_back('{wrin(1'b0), ex(8'b0001_1000, 16'h1234, 3'b000, 16'h0000)});
        tbl.push_back('{wrin(1'b0), ex(8'b0001_1000, 16'hA5A5, 3'b000, 16'h0000)});
        tbl.push_back('{wrin(1'b0), ex(8'b0011_0000, 16'hA5A5, 3'b000, 16'h0000)});
        tbl.push_back('{wrin(1'b0), ex(8'b0011_0000, 16'hA5A5, 3'b000, 16'h0000)});
        tbl.push_back('{wrin(1'b0), ex(8'b0011_1110, 16'hA5A5, 3'b000, 16'h0000)});
        tbl.push_back('{wrin(1'b0), ex(8'b0011_1100, 16'hBEEF, 3'b100, 16'h0000)});
        tbl.push_back('{wrin(1'b0), ex(8'b0110_0000, 16'hBEEF, 3'b101, 16'h0000)});
        tbl.push_back('{rdin(1'b1, 16'hDEAD), ex(8'b1110_0000, 16'hBEEF, 3'b100, 16'h0000)});
        tbl.push_back('{rdin(1'b0, 16'hDEAD), ex(8'b0001_1000, 16'h2468, 3'b100, 16'h0000)});
        tbl.push_back('{rdin(1'b0, 16'hDEAD), ex(8'b0001_1000, 16'h1357, 3'b100, 16'h0000)});
        tbl.push_back('{rdin(1'b0, 16'hDEAD), ex(8'b0011_0000, 16'h1357, 3'b100, 16'h0000)});
        tbl.push_back('{rdin(1'b0, 16'hDEAD), ex(8'b0011_0000, 16'h1357, 3'b100, 16'h0000)});
        for (int k = 0; k < 4; k++) begin
            tbl.push_back('{rdin(1'b0, 16'hDEAD),
                            ex(8'b0011_0001, 16'h1357, 3'b100, 16'h0000)});
        end
        tbl.push_back('{rdin(1'b0, 16'h1111), ex(8'b0011_0001, 16'h1357, 3'b100, 16'h0000)});
        tbl.push_back('{rdin(1'b0, 16'h2222), ex(8'b0011_0001, 16'h1357, 3'b110, 16'h1111)});
        tbl.push_back('{rdin(1'b0, 16'hDEAD), ex(8'b0110_0000, 16'h1357, 3'b111, 16'h2222)});
        tbl.push_back('{rdin(1'b0, 16'hDEAD), ex(8'b1110_0000, 16'h1357, 3'b100, 16'h2222)});

        rst_ni = 1'b0;
        apply('0);
        #12;
        check("reset_state", 64'(act), 64'(rst_exp));
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();

        foreach (tbl[k]) begin
            apply(tbl[k].i);
            @(negedge clk_i);
            check($sformatf("vec%0d", k), 64'(act), 64'(tbl[k].e));
            next_cycle();
        end

        // Write of four words with two stall cycles after the second word.
        req_cmd_i   = 32'h0BAD_F00D;
        req_write_i = 1'b1;
        req_len_i   = 8'd3;
        tgl = 0; clk_lo = 0; done_c = -1; prev = 1'b0;
        for (int c = 0; c < 16; c++) begin
            req_valid_i = (c == 0);
            case (c)
                5:       begin wdata_valid_i = 1'b1; wdata_i = 16'h0001; end
                6:       begin wdata_valid_i = 1'b1; wdata_i = 16'h0002; end
                9:       begin wdata_valid_i = 1'b1; wdata_i = 16'h0003; end
                10:      begin wdata_valid_i = 1'b1; wdata_i = 16'h0004; end
                default: begin wdata_valid_i = 1'b0; wdata_i = 16'hFFFF; end
            endcase
            @(negedge clk_i);
            if (c == 5) check("stall_dqs_entry", 64'(out_dqs_o), 64'(0));
            if (c > 5 && c <= 11 && out_dqs_o != prev) tgl++;
            prev = out_dqs_o;
            if (c >= 1 && c <= 11 && !clk_en_o) clk_lo++;
            if (c == 9) check("stall_db_hold", 64'(out_db_o), 64'h0002);
            if (c == 11) check("stall_last_word", 64'(out_db_o), 64'h0004);
            if (c == 11) check("stall_dqs_end", 64'(out_dqs_o), 64'(0));
            if (done_o && done_c < 0) done_c = c;
            next_cycle();
        end
        check("stall_dqs_toggles", 64'(tgl), 64'(4));
        check("stall_clk_en_low", 64'(clk_lo), 64'(2));
        check("stall_done_cycle", 64'(done_c), 64'(12));

        // Back-to-back write then read with req_valid held high.
        acc = 0; nd = 0;
        acc_c[0] = -1; acc_c[1] = -1; done_b[0] = -1; done_b[1] = -1;
        for (int c = 0; c < 40; c++) begin
            req_valid_i   = (acc < 2);
            req_write_i   = (acc == 0);
            req_cmd_i     = (acc == 0) ? 32'h1111_2222 : 32'h3333_4444;
            req_len_i     = 8'd0;
            wdata_valid_i = 1'b1;
            wdata_i       = 16'h5A5A;
            in_db_i       = 16'h0000;
            @(negedge clk_i);
            csn_h[c] = out_csn_o;
            if (req_valid_i && req_ready_o && acc < 2) begin
                acc_c[acc] = c;
                acc++;
            end
            if (done_o) begin
                if (nd < 2) done_b[nd] = c;
                nd++;
            end
            next_cycle();
        end
        fl = -1; e = -1; s = -1;
        for (int c = 0; c < 40; c++) begin
            if (fl < 0 && !csn_h[c]) fl = c;
            else if (fl >= 0 && e < 0 && csn_h[c]) e = c;
            else if (e >= 0 && s < 0 && !csn_h[c]) s = c;
        end
        check("b2b_accepts", 64'(acc), 64'(2));
        check("b2b_dones", 64'(nd), 64'(2));
        check("b2b_accept_after_done", 64'(acc_c[1]), 64'(done_b[0] + 1));
        check("b2b_csn_gap", 64'((e >= 0 && s >= 0) ? s - e : -1), 64'(2));

        // Asynchronous reset while in the write data phase.
        req_cmd_i     = 32'hCAFE_0001;
        req_write_i   = 1'b1;
        req_len_i     = 8'd3;
        wdata_valid_i = 1'b1;
        wdata_i       = 16'h7777;
        req_valid_i   = 1'b1;
        next_cycle();
        req_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2;
        check("midwrite_wready", 64'(wdata_ready_o), 64'(1));
        rst_ni = 1'b0;
        #1;
        check("reset_midwrite", 64'(act), 64'(rst_exp));
        @(negedge clk_i);
        rst_ni = 1'b1;
        wdata_valid_i = 1'b0;
        next_cycle();
        @(negedge clk_i);
        check("ready_after_reset", 64'(req_ready_o), 64'(1));
        next_cycle();

        // Maximum-length read: 256 beats.
        req_cmd_i   = 32'h0000_00FF;
        req_write_i = 1'b0;
        req_len_i   = 8'd255;
        pulses = 0; rbad = 0; first_p = -1; last_p = -1; done_c = -1;
        for (int c = 0; c < 300; c++) begin
            req_valid_i = (c == 0);
            in_db_i     = 16'(c);
            @(negedge clk_i);
            if (rdata_valid_o) begin
                pulses++;
                if (first_p < 0) first_p = c;
                last_p = c;
                if (rdata_o != 16'(c - 1)) rbad++;
            end
            if (done_o && done_c < 0) done_c = c;
            next_cycle();
            if (done_c >= 0 && c > done_c + 2) break;
        end
        check("maxlen_pulses", 64'(pulses), 64'(256));
        check("maxlen_data_errors", 64'(rbad), 64'(0));
        check("maxlen_first_beat", 64'(first_p), 64'(10));
        check("maxlen_done_cycle", 64'(done_c), 64'(265));
        check("maxlen_last_beat", 64'(last_p), 64'(265));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
